// File: rtl/uart_receiver.sv
// UART receive stage: start bit, DATA_W data bits MSB first, one stop bit; word held on a valid/ack register.
// Define UART_RX_SYNC_EN to put a 2-flop synchronizer on rx (adds 2 cycles of latency).
module uart_receiver #(
  parameter int DATA_W       = 8,
  parameter int CLKS_PER_BIT = 1
) (
  input  logic              CLK,
  input  logic              Reset,
  input  logic              rx,
  input  logic              ack,
  output logic [DATA_W-1:0] DataOUT,
  output logic              valid,
  output logic              frame_err,
  output logic              overrun
);
  localparam int HALF = (CLKS_PER_BIT - 1) / 2;
  localparam int TW   = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int CW   = $clog2(DATA_W + 1);
  localparam logic [TW-1:0] T_LAST = TW'(CLKS_PER_BIT - 1);
  localparam logic [TW-1:0] T_HALF = TW'((HALF > 0) ? (HALF - 1) : 0);
  localparam logic [CW-1:0] C_LAST = CW'(DATA_W - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_DATA  = 2'd2,
    S_STOP  = 2'd3
  } state_t;

  state_t            r_state, w_state_nx;
  logic [TW-1:0]     r_timer, w_timer_nx;
  logic [CW-1:0]     r_cnt, w_cnt_nx;
  logic [DATA_W-1:0] r_shift, w_shift_nx;
  logic [DATA_W-1:0] r_data, w_data_nx;
  logic              r_valid, w_valid_nx;
  logic              r_frame_err, w_frame_err_nx;
  logic              r_overrun, w_overrun_nx;
  logic              w_rx;
  logic              w_good;
  logic              w_ack_take;

`ifdef UART_RX_SYNC_EN
  logic [1:0] r_sync;

  always_ff @(posedge CLK or negedge Reset) begin
    if (!Reset) begin
      r_sync <= 2'b11;
    end else begin
      r_sync <= {r_sync[0], rx};
    end
  end

  assign w_rx = r_sync[1];
`else
  assign w_rx = rx;
`endif

  always_comb begin
    w_state_nx     = r_state;
    w_timer_nx     = r_timer;
    w_cnt_nx       = r_cnt;
    w_shift_nx     = r_shift;
    w_data_nx      = r_data;
    w_valid_nx     = r_valid;
    w_overrun_nx   = r_overrun;
    w_frame_err_nx = 1'b0;
    w_good         = 1'b0;
    w_ack_take     = ack & r_valid;

    case (r_state)
      S_IDLE: begin
        if (!w_rx) begin
          w_timer_nx = {TW{1'b0}};
          w_cnt_nx   = {CW{1'b0}};
          // With no half-bit wait the IDLE sample already sits mid start bit.
          w_state_nx = (HALF == 0) ? S_DATA : S_START;
        end else begin
          w_state_nx = S_IDLE;
        end
      end
      S_START: begin
        if (r_timer == T_HALF) begin
          w_timer_nx = {TW{1'b0}};
          w_state_nx = w_rx ? S_IDLE : S_DATA;
        end else begin
          w_timer_nx = r_timer + 1'b1;
        end
      end
      S_DATA: begin
        if (r_timer == T_LAST) begin
          w_timer_nx = {TW{1'b0}};
          w_shift_nx = {r_shift[DATA_W-2:0], w_rx};
          w_cnt_nx   = r_cnt + 1'b1;
          if (r_cnt == C_LAST) begin
            w_state_nx = S_STOP;
          end else begin
            w_state_nx = S_DATA;
          end
        end else begin
          w_timer_nx = r_timer + 1'b1;
        end
      end
      S_STOP: begin
        if (r_timer == T_LAST) begin
          w_timer_nx     = {TW{1'b0}};
          w_state_nx     = S_IDLE;
          w_good         = w_rx;
          w_frame_err_nx = ~w_rx;
        end else begin
          w_timer_nx = r_timer + 1'b1;
        end
      end
      default: begin
        w_state_nx = S_IDLE;
        w_timer_nx = {TW{1'b0}};
        w_cnt_nx   = {CW{1'b0}};
      end
    endcase

    // A word landing on an ack cycle replaces the consumed one without an overrun.
    if (w_good) begin
      w_data_nx    = r_shift;
      w_valid_nx   = 1'b1;
      w_overrun_nx = (r_valid & ~ack) | (r_overrun & ~w_ack_take);
    end else if (w_ack_take) begin
      w_valid_nx   = 1'b0;
      w_overrun_nx = 1'b0;
    end else begin
      w_valid_nx   = r_valid;
      w_overrun_nx = r_overrun;
    end
  end

  always_ff @(posedge CLK or negedge Reset) begin
    if (!Reset) begin
      r_state     <= S_IDLE;
      r_timer     <= {TW{1'b0}};
      r_cnt       <= {CW{1'b0}};
      r_shift     <= {DATA_W{1'b0}};
      r_data      <= {DATA_W{1'b0}};
      r_valid     <= 1'b0;
      r_frame_err <= 1'b0;
      r_overrun   <= 1'b0;
    end else begin
      r_state     <= w_state_nx;
      r_timer     <= w_timer_nx;
      r_cnt       <= w_cnt_nx;
      r_shift     <= w_shift_nx;
      r_data      <= w_data_nx;
      r_valid     <= w_valid_nx;
      r_frame_err <= w_frame_err_nx;
      r_overrun   <= w_overrun_nx;
    end
  end

  assign DataOUT   = r_data;
  assign valid     = r_valid;
  assign frame_err = r_frame_err;
  assign overrun   = r_overrun;
endmodule

// File: tb/tb_uart_receiver.sv
// Scoreboard bench for uart_receiver: one instance at 1 clk/bit, one at 16 clk/bit.
module tb_uart_receiver;
`ifdef UART_RX_SYNC_EN
  localparam int SYNC_LAT = 2;
`else
  localparam int SYNC_LAT = 0;
`endif

  logic       clk = 1'b0;
  logic       rst_n;
  logic       rx, ack, rx16, ack16;
  logic [7:0] dout, dout16;
  logic       valid, frame_err, overrun;
  logic       valid16, frame_err16, overrun16;

  int n_tests = 0;
  int n_fail  = 0;

  logic [7:0] q1[$];
  logic [7:0] q16[$];
  logic       m1_pv = 1'b0, m16_pv = 1'b0;
  logic [7:0] m1_pd = 8'h00, m16_pd = 8'h00;

  always #5 clk = ~clk;

  uart_receiver #(.DATA_W(8), .CLKS_PER_BIT(1)) u_dut (
    .CLK(clk), .Reset(rst_n), .rx(rx), .ack(ack),
    .DataOUT(dout), .valid(valid), .frame_err(frame_err), .overrun(overrun)
  );

  uart_receiver #(.DATA_W(8), .CLKS_PER_BIT(16)) u_dut16 (
    .CLK(clk), .Reset(rst_n), .rx(rx16), .ack(ack16),
    .DataOUT(dout16), .valid(valid16), .frame_err(frame_err16), .overrun(overrun16)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop_b, input logic ack_at_stop);
    logic [9:0] bits;
    int n;
    bits = {1'b0, d, stop_b};
    n = ack_at_stop ? (10 + SYNC_LAT) : 10;
    for (int e = 0; e < n; e++) begin
      rx  = (e < 10) ? bits[9-e] : 1'b1;
      ack = (ack_at_stop && (e == 9 + SYNC_LAT)) ? 1'b1 : 1'b0;
      tick();
    end
    rx  = 1'b1;
    ack = 1'b0;
  endtask

  task automatic send16(input logic [7:0] d);
    logic [9:0] bits;
    bits = {1'b0, d, 1'b1};
    for (int e = 0; e < 10; e++) begin
      rx16 = bits[9-e];
      repeat (16) tick();
    end
    rx16 = 1'b1;
  endtask

  task automatic wait_valid(output int c);
    c = 0;
    while (!valid && c < 40) begin
      tick();
      c++;
    end
  endtask

  // Scoreboard monitor, 1 clk/bit instance: a new word is valid rising or DataOUT changing while valid.
  always @(negedge clk) begin
    if (valid && (!m1_pv || dout != m1_pd)) begin
      if (q1.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL sb1_unexpected: got %0h expected none", dout);
      end else begin
        check("sb1_word", {24'h0, dout}, {24'h0, q1.pop_front()});
      end
    end
    m1_pv <= valid;
    m1_pd <= dout;
  end

  // Scoreboard monitor, 16 clk/bit instance.
  always @(negedge clk) begin
    if (valid16 && (!m16_pv || dout16 != m16_pd)) begin
      if (q16.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL sb16_unexpected: got %0h expected none", dout16);
      end else begin
        check("sb16_word", {24'h0, dout16}, {24'h0, q16.pop_front()});
      end
    end
    m16_pv <= valid16;
    m16_pd <= dout16;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int c;
    int fe_cnt;
    int v_seen;
    rst_n = 1'b0;
    rx    = 1'b1;
    ack   = 1'b0;
    rx16  = 1'b1;
    ack16 = 1'b0;
    #3;
    check("rst_data", {24'h0, dout}, 32'h0);
    check("rst_valid", {31'h0, valid}, 32'h0);
    check("rst_ferr", {31'h0, frame_err}, 32'h0);
    check("rst_ovr", {31'h0, overrun}, 32'h0);
    #9 rst_n = 1'b1;
    tick();
    tick();

    // 1: single frame 0xA5, then ack; ack while empty is ignored
    q1.push_back(8'hA5);
    send_frame(8'hA5, 1'b1, 1'b0);
    wait_valid(c);
    check("t1_latency", c, SYNC_LAT);
    check("t1_data", {24'h0, dout}, 32'hA5);
    ack = 1'b1;
    tick();
    ack = 1'b0;
    check("t1_ack_clears", {31'h0, valid}, 32'h0);
    ack = 1'b1;
    tick();
    ack = 1'b0;
    check("t1_idle_ack_valid", {31'h0, valid}, 32'h0);
    check("t1_idle_ack_ovr", {31'h0, overrun}, 32'h0);

    // 2: back-to-back 0x3C, 0xC3 without ack -> overrun
    q1.push_back(8'h3C);
    q1.push_back(8'hC3);
    send_frame(8'h3C, 1'b1, 1'b0);
    send_frame(8'hC3, 1'b1, 1'b0);
    repeat (SYNC_LAT) tick();
    check("t2_data", {24'h0, dout}, 32'hC3);
    check("t2_valid", {31'h0, valid}, 32'h1);
    check("t2_overrun", {31'h0, overrun}, 32'h1);
    ack = 1'b1;
    tick();
    ack = 1'b0;
    check("t2_ack_valid", {31'h0, valid}, 32'h0);
    check("t2_ack_ovr", {31'h0, overrun}, 32'h0);

    // 3: bad stop bit -> one-cycle frame_err, then a good 0x81
    send_frame(8'h5A, 1'b0, 1'b0);
    fe_cnt = 0;
    v_seen = 0;
    for (int i = 0; i < 6; i++) begin
      if (frame_err) fe_cnt++;
      if (valid) v_seen++;
      tick();
    end
    check("t3_ferr_cycles", fe_cnt, 1);
    check("t3_no_valid", v_seen, 0);
    check("t3_no_ovr", {31'h0, overrun}, 32'h0);
    q1.push_back(8'h81);
    send_frame(8'h81, 1'b1, 1'b0);
    wait_valid(c);
    check("t3_latency", c, SYNC_LAT);
    check("t3_data", {24'h0, dout}, 32'h81);

    // 5: async reset after 4 data bits of 0x77 (0,1,1,1)
    rx = 1'b0; tick();
    rx = 1'b0; tick();
    rx = 1'b1; tick();
    rx = 1'b1; tick();
    rx = 1'b1; tick();
    #2 rst_n = 1'b0;
    #1;
    check("t5_rst_data", {24'h0, dout}, 32'h0);
    check("t5_rst_valid", {31'h0, valid}, 32'h0);
    check("t5_rst_ovr", {31'h0, overrun}, 32'h0);
    rx = 1'b1;
    tick();
    #3 rst_n = 1'b1;
    tick();
    tick();
    q1.push_back(8'h12);
    send_frame(8'h12, 1'b1, 1'b0);
    wait_valid(c);
    check("t5_latency", c, SYNC_LAT);
    check("t5_data", {24'h0, dout}, 32'h12);

    // 6: 0x34 completes on the same edge that acks 0x12
    q1.push_back(8'h34);
    send_frame(8'h34, 1'b1, 1'b1);
    check("t6_valid", {31'h0, valid}, 32'h1);
    check("t6_ovr", {31'h0, overrun}, 32'h0);
    check("t6_data", {24'h0, dout}, 32'h34);
    ack = 1'b1;
    tick();
    ack = 1'b0;
    check("t6_ack_valid", {31'h0, valid}, 32'h0);

    // 4: 16 clk/bit false start, then full 0xFF frame
    rx16 = 1'b0;
    repeat (4) tick();
    rx16 = 1'b1;
    repeat (20) tick();
    check("t4_false_start", {31'h0, valid16}, 32'h0);
    check("t4_false_ferr", {31'h0, frame_err16}, 32'h0);
    q16.push_back(8'hFF);
    send16(8'hFF);
    check("t4_valid", {31'h0, valid16}, 32'h1);
    check("t4_data", {24'h0, dout16}, 32'hFF);
    check("t4_ovr", {31'h0, overrun16}, 32'h0);

    repeat (3) tick();
    check("sb1_drained", q1.size(), 0);
    check("sb16_drained", q16.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
